// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, core FSM states, the inverse S-box
// and GF(2^8) helpers used by the inverse round logic.
package aes_pkg;

  localparam int NUM_ROUNDS = 14;
  localparam int NUM_COLS   = 4;

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; with a constant operand this folds to an XOR network.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round_fun.sv
// Combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skippable for the final round).
module aes_inv_round_fun
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         bypass_mix,
  output logic [127:0] result
);

  // Byte i of these arrays is state byte i (r + 4c), not the packed bit slot.
  logic [15:0][7:0] ak;
  logic [15:0][7:0] mx;

  // Per byte: row r is rotated right by r, so s'[r][c] comes from s[r][c-r].
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R   = i % 4;
    localparam int C   = i / 4;
    localparam int SRC = R + 4 * ((C + 4 - R) % 4);
    assign ak[i] = INV_SBOX[state[127-8*SRC -: 8]] ^ key[127-8*i -: 8];
    assign result[127-8*i -: 8] = bypass_mix ? ak[i] : mx[i];
  end

  // Per column: circulant {0e,0b,0d,09} product.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign mx[4*c+r] = gmul(ak[4*c+r],         8'h0e)
                       ^ gmul(ak[4*c+(r+1)%4],   8'h0b)
                       ^ gmul(ak[4*c+(r+2)%4],   8'h0d)
                       ^ gmul(ak[4*c+(r+3)%4],   8'h09);
    end
  end

endmodule

// File: rtl/aes_dec_round_iter.sv
// Iterative AES-256 decrypt core: one inverse round per clock, round keys
// fetched by index from an external zero-latency key store.
module aes_dec_round_iter #(
  parameter int NUM_ROUNDS = 14,
  parameter int KEY_IDX_W  = 4
)(
  input  logic                 inClk,
  input  logic                 inRst,
  input  logic                 inValid,
  output logic                 outReady,
  input  logic [127:0]         inData,
  output logic [KEY_IDX_W-1:0] outKeyIdx,
  input  logic [127:0]         inRoundKey,
  output logic                 outValid,
  input  logic                 inReady,
  output logic [127:0]         outData
);
  import aes_pkg::state_e, aes_pkg::IDLE, aes_pkg::ROUND, aes_pkg::LAST, aes_pkg::DONE;

  typedef logic [KEY_IDX_W-1:0] idx_t;
  localparam idx_t IDX_TOP   = idx_t'(NUM_ROUNDS);
  localparam idx_t IDX_FIRST = idx_t'(NUM_ROUNDS - 1);

  state_e       st, st_nxt;
  idx_t         ctr;
  logic [127:0] blk;
  logic [127:0] rf_out;
  logic         last_rnd;

  assign last_rnd = (st == LAST);

  aes_inv_round_fun u_rf (
    .state      (blk),
    .key        (inRoundKey),
    .bypass_mix (last_rnd),
    .result     (rf_out)
  );

  // State register.
  always_ff @(posedge inClk) begin
    if (inRst) st <= IDLE;
    else       st <= st_nxt;
  end

  // Next-state: accept in IDLE, walk rounds, finish, wait for the consumer.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:  if (inValid) st_nxt = ROUND;
      ROUND: if (ctr == idx_t'(1)) st_nxt = LAST;
      LAST:  st_nxt = DONE;
      DONE:  if (inReady) st_nxt = IDLE;
    endcase
  end

  // Handshake and key index depend only on state/counter, never on inputs.
  always_comb begin
    outReady  = (st == IDLE);
    outKeyIdx = '0;
    unique case (st)
      IDLE:  outKeyIdx = IDX_TOP;
      ROUND: outKeyIdx = ctr;
      LAST:  outKeyIdx = '0;
      DONE:  outKeyIdx = '0;
    endcase
  end

  // Datapath: initial K14 whitening on accept, inverse rounds, final round into outData.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      blk      <= '0;
      ctr      <= IDX_TOP;
      outData  <= '0;
      outValid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (inValid) begin
          blk <= inData ^ inRoundKey;
          ctr <= IDX_FIRST;
        end
        ROUND: begin
          blk <= rf_out;
          ctr <= ctr - idx_t'(1);
        end
        LAST: begin
          outData  <= rf_out;
          outValid <= 1'b1;
        end
        DONE: if (inReady) begin
          outValid <= 1'b0;
          ctr      <= IDX_TOP;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_dec_round_iter.md
Name: aes_dec_round_iter

Overview:
- Iterative AES-256 block decryption core. It computes one inverse round per clock and is the decrypt-direction counterpart of the combinational encrypt round chain.
- Consumes one 128-bit ciphertext block and produces one 128-bit plaintext block.
- Round keys are fetched one per cycle through an index/key lookup port served by the key-schedule storage.
- Sits in the XTS block-operation datapath, on the decrypt path after the tweak XOR.

Parameters:
- NUM_ROUNDS, 14, AES-256 round count. Fixed; other values are not supported.
- KEY_IDX_W, 4, width of the round-key index.

Ports:
- inClk  input  1  clock, rising edge
- inRst  input  1  reset, synchronous, active-high
- inValid  input  1  ciphertext block offered
- outReady  output  1  core can accept a block; high only in IDLE
- inData  input  128  ciphertext; bits[127:120] = byte 0; state s[r][c] = byte r+4c (FIPS-197 order)
- outKeyIdx  output  4  index of the round key required this cycle
- inRoundKey  input  128  round key for outKeyIdx; must be valid combinationally in the same cycle
- outValid  output  1  plaintext available
- inReady  input  1  downstream accepts plaintext
- outData  output  128  plaintext, same byte order as inData

Behaviour:
- States:
  - IDLE: outReady=1, outKeyIdx=14.
  - ROUND: outKeyIdx counts 13 down to 1.
  - LAST: outKeyIdx=0.
  - DONE: outValid=1, outKeyIdx=0.
- Reset (synchronous, inRst=1 at an edge):
  - state=IDLE, outValid=0, outData=0, round counter=14, internal state register=0.
  - outReady=1 from the first cycle after reset.
- IDLE + inValid at an edge:
  - state_reg <= inData ^ inRoundKey (K14).
  - counter <= 13; go to ROUND.
- IDLE without inValid: hold.
- ROUND, each edge:
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ K[counter]).
  - counter decrements.
  - When counter==1 at the edge: counter <= 0, go to LAST.
- LAST edge:
  - outData <= InvSubBytes(InvShiftRows(state_reg)) ^ K0.
  - outValid <= 1; go to DONE.
- DONE:
  - outData and outValid are held stable while inReady=0.
  - On an edge with inReady=1: outValid <= 0, counter <= 14, go to IDLE.
  - outData keeps its last value after the handshake.
  - No same-cycle accept: outReady=0 in DONE.
- Latency:
  - outValid rises 14 edges after the accepting edge.
  - Minimum block-to-block spacing is 16 cycles (accept, 13 ROUND, LAST, DONE handshake, then IDLE).
- inValid outside IDLE is ignored; inData is sampled only on the accepting edge.
- inRoundKey is sampled every active cycle. The key source must track outKeyIdx with zero-cycle latency.
- Reset mid-operation: the in-flight block is discarded and all outputs return to reset values on the next edge. No partial output is ever flagged valid.
- outReady, outKeyIdx: decoded combinationally from state/counter only, never from inputs.
- outValid, outData: registered.
- GF(2^8) arithmetic in InvMixColumns uses polynomial 0x11B with coefficients {0e,0b,0d,09}.

Decomposition:
- Shared package aes_pkg:
  - inverse S-box table (256x8)
  - NUM_ROUNDS=14
  - state enum {IDLE, ROUND, LAST, DONE}
  - xtime/gmul helper functions
- One combinational sub-module: aes_inv_round_fun.
  - Inputs: state, key, bypass_mix.
  - Performs InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
  - Used for both ROUND (bypass_mix=0) and LAST (bypass_mix=1).
- The initial K14 XOR stays inline in the core.

Test Plan:
- FIPS-197 C.3 vector. Bench key model expands key 000102...1f and serves outKeyIdx.
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089, inReady=1.
  - Required: outData=00112233445566778899aabbccddeeff, outValid high exactly 14 edges after accept, one cycle wide.
- Key index sequence: record outKeyIdx each cycle from accept through DONE.
  - Required: 14 (accept), 13,12,...,1, then 0 (LAST), then 0 held in DONE.
- Backpressure: hold inReady=0 for 20 cycles after outValid rises.
  - Required: outData/outValid stable; outReady=0; inValid pulses ignored.
  - On release: IDLE and outReady=1 the next cycle.
- Back-to-back: inValid held high with two blocks (C.3 vector, then all-zero ciphertext).
  - Required: second accept occurs on the first IDLE cycle; both results match the reference model.
  - Accepts are spaced 16 cycles apart.
- Reset mid-operation: assert inRst at ROUND with outKeyIdx=7.
  - Required next cycle: outValid=0, outData=0, outReady=1, outKeyIdx=14.
  - A new C.3 block afterwards decrypts correctly.
- Randomized: 1000 random key/ciphertext pairs with random inValid/inReady gaps.
  - Required: every output matches the software AES-256 decrypt model.
  - No output is lost or duplicated.
